// File: rtl/arbitrated_bus_if.sv
// Shared-bus bundle: requester data, request and lock lines in, and the
// arbitration results (grant, owner, bus value, contention) back out.
interface arbitrated_bus_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 8
);
  localparam int ENC = $clog2(COUNT + 1);

  logic [WIDTH*COUNT-1:0] in;
  logic [COUNT-1:0]       req;
  logic [COUNT-1:0]       lock;
  logic [COUNT-1:0]       grant;
  logic [ENC-1:0]         owner;
  logic                   busy;
  logic [WIDTH-1:0]       out;
  logic                   conflict;
  logic [7:0]             conflict_count;

  modport master (
    output in, req, lock,
    input  grant, owner, busy, out, conflict, conflict_count
  );

  modport slave (
    input  in, req, lock,
    output grant, owner, busy, out, conflict, conflict_count
  );
endinterface

// File: rtl/arbitrated_bus.sv
// Clocked shared-bus arbiter: fixed-priority or round-robin ownership with
// owner lock, optional idle keeper and a saturating contention counter.
module arbitrated_bus #(
  parameter int               WIDTH         = 8,
  parameter int               COUNT         = 8,
  parameter logic [WIDTH-1:0] DEFAULT_VALUE = '1,
  parameter int               ROUND_ROBIN   = 0,
  parameter int               KEEPER        = 0
) (
  input logic               clk,
  input logic               reset,
  arbitrated_bus_if.slave   bus
);
  localparam int ENC = $clog2(COUNT + 1);
  localparam int PW  = $clog2(COUNT);

  logic [COUNT-1:0] grant_q, grant_d;
  logic [ENC-1:0]   owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;
  logic [7:0]       count_q;
  logic [WIDTH-1:0] keep_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] out_w;
  logic [PW-1:0]    win;
  logic             hold;
  logic             any_req;

  // Bus value: owner's live data while busy, otherwise the idle value.
  always_comb begin
    out_w = (KEEPER != 0) ? keep_q : DEFAULT_VALUE;
    if (busy_q) begin
      for (int i = 0; i < COUNT; i++) begin
        if (grant_q[i]) out_w = bus.in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign hold    = busy_q && (|(grant_q & bus.req & bus.lock));
  assign any_req = |bus.req;

  // Winner selection; round-robin starts searching just past the last winner.
  always_comb begin
    int            c;
    logic [PW-1:0] idx;
    logic          found;
    win   = '0;
    c     = 0;
    idx   = '0;
    found = 1'b0;
    if (ROUND_ROBIN != 0) begin
      for (int k = 1; k <= COUNT; k++) begin
        c   = (int'(ptr_q) + k) % COUNT;
        idx = PW'(c);
        if (!found && bus.req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        if (bus.req[i]) win = PW'(i);
      end
    end
  end

  always_comb begin
    grant_d    = grant_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    conflict_d = 1'b0;
    if (!hold) begin
      if (any_req) begin
        grant_d      = '0;
        grant_d[win] = 1'b1;
        owner_d      = ENC'(win) + ENC'(1);
        busy_d       = 1'b1;
        if (ROUND_ROBIN != 0) ptr_d = win;
        conflict_d   = ($countones(bus.req) > 1);
      end else begin
        grant_d = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      count_q    <= '0;
      keep_q     <= DEFAULT_VALUE;
      ptr_q      <= PW'(COUNT - 1);
    end else begin
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      ptr_q      <= ptr_d;
      if (conflict_d && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
      if (busy_q) keep_q <= out_w;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.owner          = owner_q;
  assign bus.busy           = busy_q;
  assign bus.out            = out_w;
  assign bus.conflict       = conflict_q;
  assign bus.conflict_count = count_q;
endmodule

// File: tb/tb_arbitrated_bus.sv
// Directed bench for arbitrated_bus: fixed, round-robin and keeper variants
// driven in one linear sequence with hand-computed expectations.
module tb_arbitrated_bus;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  arbitrated_bus_if #(.WIDTH(8), .COUNT(8)) bf ();
  arbitrated_bus_if #(.WIDTH(8), .COUNT(4)) br ();
  arbitrated_bus_if #(.WIDTH(8), .COUNT(8)) bk ();

  arbitrated_bus #(.WIDTH(8), .COUNT(8), .ROUND_ROBIN(0), .KEEPER(0)) dut_fixed (
    .clk(clk), .reset(reset), .bus(bf.slave));
  arbitrated_bus #(.WIDTH(8), .COUNT(4), .ROUND_ROBIN(1), .KEEPER(0)) dut_rr (
    .clk(clk), .reset(reset), .bus(br.slave));
  arbitrated_bus #(.WIDTH(8), .COUNT(8), .ROUND_ROBIN(0), .KEEPER(1)) dut_keep (
    .clk(clk), .reset(reset), .bus(bk.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, then settle on the falling edge for sampling.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bf.in = '0; bf.req = '0; bf.lock = '0;
    br.in = '0; br.req = '0; br.lock = '0;
    bk.in = '0; bk.req = '0; bk.lock = '0;
    #2;
    checkOutput("reset_grant", 32'(bf.grant), 32'h0);
    checkOutput("reset_owner", 32'(bf.owner), 32'h0);
    checkOutput("reset_out", 32'(bf.out), 32'hFF);
    checkOutput("reset_keep_out", 32'(bk.out), 32'hFF);

    @(negedge clk);
    reset = 1'b0;
    applyStimulus(3);
    checkOutput("idle_grant", 32'(bf.grant), 32'h0);
    checkOutput("idle_busy", 32'(bf.busy), 32'h0);
    checkOutput("idle_out", 32'(bf.out), 32'hFF);
    checkOutput("idle_count", 32'(bf.conflict_count), 32'h0);

    $display("[TB] fixed priority");
    bf.in[2*8 +: 8] = 8'h55;
    bf.in[4*8 +: 8] = 8'hA0;
    bf.req = 8'b0001_0100;
    applyStimulus(1);
    checkOutput("fix_owner", 32'(bf.owner), 32'h5);
    checkOutput("fix_grant", 32'(bf.grant), 32'h10);
    checkOutput("fix_out", 32'(bf.out), 32'hA0);
    checkOutput("fix_conflict", 32'(bf.conflict), 32'h1);
    checkOutput("fix_count", 32'(bf.conflict_count), 32'h1);
    bf.req = '0;
    applyStimulus(1);
    checkOutput("fix_release_conflict", 32'(bf.conflict), 32'h0);
    checkOutput("fix_release_out", 32'(bf.out), 32'hFF);
    checkOutput("fix_release_count", 32'(bf.conflict_count), 32'h1);

    $display("[TB] round robin");
    br.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1);
      checkOutput("rr_owner", 32'(br.owner), 32'((k % 4) + 1));
      checkOutput("rr_grant", 32'(br.grant), 32'(1 << (k % 4)));
    end
    checkOutput("rr_count", 32'(br.conflict_count), 32'h8);
    br.req = '0;

    $display("[TB] lock");
    bf.in[1*8 +: 8] = 8'h11;
    bf.in[3*8 +: 8] = 8'h33;
    bf.in[5*8 +: 8] = 8'h5A;
    bf.req  = 8'b0000_0010;
    bf.lock = 8'b0000_0010;
    applyStimulus(1);
    checkOutput("lock_owner", 32'(bf.owner), 32'h2);
    bf.req = 8'b0000_1010;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput("lock_hold_owner", 32'(bf.owner), 32'h2);
      checkOutput("lock_hold_conflict", 32'(bf.conflict), 32'h0);
    end
    checkOutput("lock_hold_out", 32'(bf.out), 32'h11);
    checkOutput("lock_hold_count", 32'(bf.conflict_count), 32'h1);
    bf.req = 8'b0000_1000;
    applyStimulus(1);
    checkOutput("lock_drop_owner", 32'(bf.owner), 32'h4);
    checkOutput("lock_drop_out", 32'(bf.out), 32'h33);
    bf.req  = 8'b0010_1000;
    bf.lock = 8'b0010_0000;
    applyStimulus(1);
    checkOutput("nonowner_lock_owner", 32'(bf.owner), 32'h6);
    checkOutput("nonowner_lock_conflict", 32'(bf.conflict), 32'h1);
    checkOutput("nonowner_lock_count", 32'(bf.conflict_count), 32'h2);
    checkOutput("nonowner_lock_out", 32'(bf.out), 32'h5A);

    $display("[TB] keeper");
    bf.lock = '0;
    bf.in[0 +: 8] = 8'h3C;
    bk.in[0 +: 8] = 8'h3C;
    bf.req = 8'b0000_0001;
    bk.req = 8'b0000_0001;
    applyStimulus(1);
    checkOutput("keep_drive_out", 32'(bk.out), 32'h3C);
    checkOutput("nokeep_drive_out", 32'(bf.out), 32'h3C);
    bf.req = '0;
    bk.req = '0;
    applyStimulus(1);
    bk.in[0 +: 8] = 8'h00;
    bf.in[0 +: 8] = 8'h00;
    #1;
    checkOutput("keep_idle_busy", 32'(bk.busy), 32'h0);
    checkOutput("keep_idle_out", 32'(bk.out), 32'h3C);
    checkOutput("nokeep_idle_out", 32'(bf.out), 32'hFF);
    applyStimulus(2);
    checkOutput("keep_idle_out_later", 32'(bk.out), 32'h3C);

    $display("[TB] async reset mid-lock");
    bf.in[2*8 +: 8] = 8'h77;
    bf.req  = 8'b0000_0100;
    bf.lock = 8'b0000_0100;
    applyStimulus(1);
    checkOutput("pre_reset_owner", 32'(bf.owner), 32'h3);
    checkOutput("pre_reset_out", 32'(bf.out), 32'h77);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_grant", 32'(bf.grant), 32'h0);
    checkOutput("async_reset_owner", 32'(bf.owner), 32'h0);
    checkOutput("async_reset_out", 32'(bf.out), 32'hFF);
    checkOutput("async_reset_count", 32'(bf.conflict_count), 32'h0);
    @(negedge clk);
    checkOutput("reset_held_busy", 32'(bf.busy), 32'h0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("post_reset_owner", 32'(bf.owner), 32'h3);

    $display("[TB] counter saturation");
    br.req = 4'b1111;
    applyStimulus(254);
    checkOutput("sat_count_254", 32'(br.conflict_count), 32'd254);
    applyStimulus(46);
    checkOutput("sat_count_255", 32'(br.conflict_count), 32'd255);
    checkOutput("sat_conflict", 32'(br.conflict), 32'h1);
    br.req = '0;
    applyStimulus(1);
    checkOutput("sat_idle_count", 32'(br.conflict_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/arbitrated_bus.md
Name: arbitrated_bus

Overview:
Shared-bus driver with registered arbitration. It generalises the combinational priority bus mux into a clocked arbiter. Up to COUNT requesters drive a packed data input and request lines. The block selects one owner per cycle using fixed-priority or round-robin mode, and supports multi-cycle lock for atomic transfers. It optionally holds the last driven value when the bus is idle (keeper), and reports contention. It sits between the CPU's bus sources (registers, ALU, memory) and the shared data bus.

Parameters:
WIDTH, 8, bus width in bits
COUNT, 8, number of requesters (≥2)
DEFAULT_VALUE, ~0 (all ones at WIDTH), idle bus value when KEEPER=0 ("pulled up")
ROUND_ROBIN, 0, 0 = fixed priority (highest index wins), 1 = round-robin
KEEPER, 0, 0 = idle bus shows DEFAULT_VALUE, 1 = idle bus holds last driven value
(localparam ENC = $clog2(COUNT+1))

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in  input  WIDTH*COUNT  packed requester data; channel i at in[(i+1)*WIDTH-1 : i*WIDTH]
req  input  COUNT  request per channel
lock  input  COUNT  lock per channel; meaningful only from the current owner
grant  output  COUNT  registered one-hot grant; all zero when idle
owner  output  ENC  registered owner code: 0 = none, i+1 = channel i
busy  output  1  registered; 1 when any grant is active
out  output  WIDTH  bus value
conflict  output  1  registered one-cycle pulse
conflict_count  output  8  saturating contention counter

Behaviour:
- Reset (async, immediate): grant=0, owner=0, busy=0, conflict=0, conflict_count=0, keeper register=DEFAULT_VALUE, round-robin pointer=COUNT-1.
- req is sampled on each rising edge. grant, owner and busy update on that edge, giving 1 cycle latency from req to grant.
- out is combinational from registered state and live in:
  - busy=1: out = in slice of owner-1.
  - busy=0, KEEPER=0: out = DEFAULT_VALUE.
  - busy=0, KEEPER=1: out = keeper register.
- Keeper register loads the current out on every edge where busy=1. It is always maintained but only visible when KEEPER=1.
- State per edge, evaluated in this order:
  - HOLD: busy=1 and req[o]=1 and lock[o]=1 (o = current owner channel) → owner, grant and pointer unchanged, regardless of other requests.
  - ARBITRATE, fixed mode: the highest-index channel with req=1 wins.
  - ARBITRATE, round-robin mode: search channels ptr+1, ptr+2, … with modulo-COUNT wrap; the first with req=1 wins, and ptr ← winner.
  - No req at all → idle: grant=0, owner=0, busy=0, ptr unchanged.
- Owner dropping req releases the bus at the next edge even if its lock is still high.
- lock from a non-owner is ignored.
- A new winner may be granted on the same edge the previous owner releases. There is no dead cycle.
- Re-arbitration with no lock may re-grant the same channel. In round-robin mode that only happens if it is the sole requester or next in rotation.
- conflict is set for exactly the cycle following any edge where popcount(req) ≥ 2 and the block was in the ARBITRATE case. It is not set during HOLD.
- conflict_count increments on each such edge and saturates at 255; it does not wrap.
- grant is always one-hot or zero. owner equals the index of the set grant bit plus 1.
- Reset asserted mid-transfer or mid-lock: all state cleared immediately and out falls to the idle value. Re-arbitration starts on the first edge after reset deasserts.

Test Plan:
1. Reset then idle: reset=1 → grant=0, owner=0, out=8'hFF (KEEPER=0); release reset, req=0 for 3 cycles → outputs unchanged, conflict_count=0.
2. Fixed priority: req=8'b0001_0100, in ch2=8'h55, ch4=8'hA0 → after 1 edge owner=5, grant=8'h10, out=8'hA0, conflict=1 for one cycle, conflict_count=1.
3. Round-robin fairness (ROUND_ROBIN=1, COUNT=4): req=4'b1111 held for 8 edges → owners 1,2,3,4,1,2,3,4; conflict_count=8.
4. Lock: ch1 granted with lock[1]=1 while ch3 also requests for 4 cycles → owner stays 2, no conflict pulses; ch1 drops req → next edge owner=4.
5. Keeper (KEEPER=1): ch0 drives 8'h3C, then req=0 → out stays 8'h3C while busy=0; same sequence with KEEPER=0 → out=8'hFF.
6. Async reset mid-lock and counter saturation: assert reset between edges during a lock → grant=0 immediately, out=DEFAULT_VALUE. Separately, 300 contended edges → conflict_count=255.
